// File: rtl/pfr_spi_pkg.sv
// Shared definitions for the PFR SPI master: FSM state encoding and the
// half-period divider counter width.
package pfr_spi_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD   = 3'd1,
    ST_XFER   = 3'd2,
    ST_TRAIL  = 3'd3,
    ST_CSWAIT = 3'd4
  } pfr_spi_state_e;

endpackage

// File: rtl/pfr_spi_clkdiv.sv
// Half-period tick generator: tick is high for one cycle out of every CLKDIV.
// The counter restarts from zero whenever clear is asserted (state entry).
module pfr_spi_clkdiv
  import pfr_spi_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic clear,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLKDIV - 1);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pfr_spi_master.sv
// Byte-wide SPI mode-0 master driving the PFR SPI pins, with optional
// chip-select hold between consecutive bytes.
module pfr_spi_master
  import pfr_spi_pkg::*;
#(
  parameter int CLKDIV = 2
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           ENABLE,
  input  logic           START,
  input  logic           CSHOLD,
  input  logic [7:0]     TXDATA,
  output logic [7:0]     RXDATA,
  output logic           BUSY,
  output logic           DONE,
  output logic           PFRMCLKO,
  output logic           PFRMOSIO,
  output logic           PFRCSNO,
  output logic           PFRMCLKOE,
  output logic           PFRMOSIOE,
  output logic           PFRCSNOE,
  output logic           PFRMISOO,
  output logic           PFRMISOOE,
  input  logic           PFRMISOI,
  output pfr_spi_state_e DBG_STATE
);

  // Handshake: START is accepted on a rising CLK edge only when ENABLE=1 and
  // BUSY=0 (IDLE or CSWAIT); TXDATA is captured on that edge. START seen
  // while BUSY=1 is dropped, never queued. DONE pulses once per byte.

  pfr_spi_state_e state, state_next;
  logic           tick, div_clear;
  logic           load, rise, fall, last;
  logic [3:0]     bit_cnt;
  logic [6:0]     tx_shift;
  logic [7:0]     rx_shift;

  pfr_spi_clkdiv #(.CLKDIV(CLKDIV)) u_clkdiv (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .clear (div_clear),
    .tick  (tick)
  );

  assign div_clear = (state_next != state);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    rise       = 1'b0;
    fall       = 1'b0;
    last       = 1'b0;
    if (!ENABLE) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            load       = 1'b1;
            state_next = ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (tick) state_next = ST_XFER;
        end
        ST_XFER: begin
          // Odd ticks (bit_cnt even) raise SCLK, even ticks lower it.
          if (tick) begin
            rise = ~bit_cnt[0];
            fall = bit_cnt[0];
            if (bit_cnt == 4'd15) begin
              last       = 1'b1;
              state_next = CSHOLD ? ST_CSWAIT : ST_TRAIL;
            end
          end
        end
        ST_TRAIL: begin
          if (tick) state_next = ST_IDLE;
        end
        ST_CSWAIT: begin
          if (START) begin
            load       = 1'b1;
            state_next = ST_XFER;
          end else if (!CSHOLD) begin
            state_next = ST_TRAIL;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      PFRMCLKO <= 1'b0;
      PFRMOSIO <= 1'b0;
      PFRCSNO  <= 1'b1;
      RXDATA   <= '0;
      DONE     <= 1'b0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
    end else if (!ENABLE) begin
      PFRMCLKO <= 1'b0;
      PFRCSNO  <= 1'b1;
      DONE     <= 1'b0;
    end else begin
      DONE    <= last;
      PFRCSNO <= (state_next == ST_IDLE);
      if (load) begin
        tx_shift <= TXDATA[6:0];
        PFRMOSIO <= TXDATA[7];
        bit_cnt  <= '0;
      end else if (tick && state == ST_XFER) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (rise) begin
        PFRMCLKO <= 1'b1;
        rx_shift <= {rx_shift[6:0], PFRMISOI};
      end
      if (fall) begin
        PFRMCLKO <= 1'b0;
        PFRMOSIO <= tx_shift[6];
        tx_shift <= {tx_shift[5:0], 1'b0};
      end
      if (last) RXDATA <= rx_shift;
    end
  end

  assign BUSY      = !(state == ST_IDLE || state == ST_CSWAIT);
  assign PFRMCLKOE = ~ENABLE;
  assign PFRMOSIOE = ~ENABLE;
  assign PFRCSNOE  = ~ENABLE;
  assign PFRMISOO  = 1'b0;
  assign PFRMISOOE = 1'b1;
  assign DBG_STATE = state;

endmodule

// File: tb/tb_pfr_spi_master.sv
// Directed bench for pfr_spi_master: three instances (CLKDIV 2, 1, 255) share
// the control inputs; each check targets one instance with its own slave MISO.
module tb_pfr_spi_master;
  import pfr_spi_pkg::*;

  logic       clk, rstn, enable, start, cshold;
  logic [7:0] txdata;
  logic [7:0] rxdata [3];
  logic busy [3], done [3], sclk [3], mosi [3], csn [3];
  logic sclk_oe [3], mosi_oe [3], csn_oe [3], miso_o [3], miso_oe [3], miso [3];
  pfr_spi_state_e st [3];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pfr_spi_master #(.CLKDIV(2)) u_div2 (
    .CLK(clk), .RSTN(rstn), .ENABLE(enable), .START(start), .CSHOLD(cshold),
    .TXDATA(txdata), .RXDATA(rxdata[0]), .BUSY(busy[0]), .DONE(done[0]),
    .PFRMCLKO(sclk[0]), .PFRMOSIO(mosi[0]), .PFRCSNO(csn[0]),
    .PFRMCLKOE(sclk_oe[0]), .PFRMOSIOE(mosi_oe[0]), .PFRCSNOE(csn_oe[0]),
    .PFRMISOO(miso_o[0]), .PFRMISOOE(miso_oe[0]), .PFRMISOI(miso[0]),
    .DBG_STATE(st[0])
  );

  pfr_spi_master #(.CLKDIV(1)) u_div1 (
    .CLK(clk), .RSTN(rstn), .ENABLE(enable), .START(start), .CSHOLD(cshold),
    .TXDATA(txdata), .RXDATA(rxdata[1]), .BUSY(busy[1]), .DONE(done[1]),
    .PFRMCLKO(sclk[1]), .PFRMOSIO(mosi[1]), .PFRCSNO(csn[1]),
    .PFRMCLKOE(sclk_oe[1]), .PFRMOSIOE(mosi_oe[1]), .PFRCSNOE(csn_oe[1]),
    .PFRMISOO(miso_o[1]), .PFRMISOOE(miso_oe[1]), .PFRMISOI(miso[1]),
    .DBG_STATE(st[1])
  );

  pfr_spi_master #(.CLKDIV(255)) u_div255 (
    .CLK(clk), .RSTN(rstn), .ENABLE(enable), .START(start), .CSHOLD(cshold),
    .TXDATA(txdata), .RXDATA(rxdata[2]), .BUSY(busy[2]), .DONE(done[2]),
    .PFRMCLKO(sclk[2]), .PFRMOSIO(mosi[2]), .PFRCSNO(csn[2]),
    .PFRMCLKOE(sclk_oe[2]), .PFRMOSIOE(mosi_oe[2]), .PFRCSNOE(csn_oe[2]),
    .PFRMISOO(miso_o[2]), .PFRMISOOE(miso_oe[2]), .PFRMISOI(miso[2]),
    .DBG_STATE(st[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0; enable = 1'b1; start = 1'b0; cshold = 1'b0; txdata = 8'h00;
    for (int i = 0; i < 3; i++) miso[i] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_sclk"},   32'(sclk[0]), 32'd0);
    check({tag, "_mosi"},   32'(mosi[0]), 32'd0);
    check({tag, "_csn"},    32'(csn[0]), 32'd1);
    check({tag, "_rxdata"}, 32'(rxdata[0]), 32'h00);
    check({tag, "_busy"},   32'(busy[0]), 32'd0);
    check({tag, "_done"},   32'(done[0]), 32'd0);
    check({tag, "_state"},  32'(st[0]), 32'(ST_IDLE));
  endtask

  // One single-byte transfer with a mode-0 slave on miso[idx]; measures DONE
  // latency, MOSI bits at SCLK rise, SCLK phase lengths and CSN release.
  task automatic run_byte(input int idx, input int div, input logic [7:0] tx,
                          input logic [7:0] slave, input bit hold, input int exp_lat,
                          input int exp_gap, input logic [7:0] exp_rx,
                          input logic [7:0] exp_mosi, input string tag);
    int k, done_k, csn_k, n_done, last_chg, sbit;
    int hi_min, hi_max, lo_min, lo_max;
    logic [7:0] mbits, rx_at_done;
    logic prev_sclk, seen_fall;
    txdata = tx; start = 1'b1; cshold = 1'b0; miso[idx] = slave[7]; sbit = 6;
    k = 0; done_k = -1; csn_k = -1; n_done = 0; last_chg = 0;
    hi_min = 1000000; hi_max = 0; lo_min = 1000000; lo_max = 0;
    mbits = 8'h00; rx_at_done = 8'h00; prev_sclk = 1'b0; seen_fall = 1'b0;
    while (csn_k < 0 && k < exp_lat + 4 * div + 20) begin
      @(negedge clk);
      k++;
      if (sclk[idx] && !prev_sclk) begin
        mbits = {mbits[6:0], mosi[idx]};
        if (seen_fall) begin
          if (k - last_chg < lo_min) lo_min = k - last_chg;
          if (k - last_chg > lo_max) lo_max = k - last_chg;
        end
        last_chg = k;
      end
      if (!sclk[idx] && prev_sclk) begin
        if (k - last_chg < hi_min) hi_min = k - last_chg;
        if (k - last_chg > hi_max) hi_max = k - last_chg;
        last_chg = k;
        seen_fall = 1'b1;
        if (sbit >= 0) begin
          miso[idx] = slave[sbit];
          sbit--;
        end
      end
      prev_sclk = sclk[idx];
      if (done[idx]) begin
        n_done++;
        done_k = k;
        rx_at_done = rxdata[idx];
      end
      if (done_k >= 0 && csn[idx]) csn_k = k;
      if (!hold) start = 1'b0;
      txdata = (k % 2 == 1) ? ~tx : 8'($urandom_range(0, 255));
    end
    check({tag, "_finished"}, 32'(csn_k >= 0), 32'd1);
    check({tag, "_done_lat"}, 32'(done_k), 32'(exp_lat));
    check({tag, "_done_cnt"}, 32'(n_done), 32'd1);
    check({tag, "_rxdata"}, 32'(rx_at_done), 32'(exp_rx));
    check({tag, "_mosi"}, 32'(mbits), 32'(exp_mosi));
    check({tag, "_csn_gap"}, 32'(csn_k - done_k), 32'(exp_gap));
    check({tag, "_hi_min"}, 32'(hi_min), 32'(div));
    check({tag, "_hi_max"}, 32'(hi_max), 32'(div));
    check({tag, "_lo_min"}, 32'(lo_min), 32'(div));
    check({tag, "_lo_max"}, 32'(lo_max), 32'(div));
  endtask

  typedef struct {
    int         idx;
    int         div;
    logic [7:0] tx;
    logic [7:0] slave;
    bit         hold;
    int         exp_lat;
    int         exp_gap;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int k, n_done, csn_hi, lead_seen, dk0, dk1, cyc;

    vecs[0] = '{0, 2,   8'hA5, 8'h3C, 1'b0, 35,   2,   8'h3C, 8'hA5};
    vecs[1] = '{0, 2,   8'hC3, 8'h5A, 1'b1, 35,   2,   8'h5A, 8'hC3};
    vecs[2] = '{1, 1,   8'h5A, 8'h81, 1'b0, 18,   1,   8'h81, 8'h5A};
    vecs[3] = '{1, 1,   8'hFF, 8'h00, 1'b0, 18,   1,   8'h00, 8'hFF};
    vecs[4] = '{2, 255, 8'hFF, 8'h00, 1'b0, 4336, 255, 8'h00, 8'hFF};

    rstn = 1'b0; enable = 1'b1; start = 1'b0; cshold = 1'b0; txdata = 8'h00;
    for (int i = 0; i < 3; i++) miso[i] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_checks("por");
    check("por_miso_o",  32'(miso_o[0]), 32'd0);
    check("por_miso_oe", 32'(miso_oe[0]), 32'd1);
    check("por_oe",      32'({sclk_oe[0], mosi_oe[0], csn_oe[0]}), 32'd0);
    rstn = 1'b1;

    for (int v = 0; v < 5; v++) begin
      apply_reset();
      run_byte(vecs[v].idx, vecs[v].div, vecs[v].tx, vecs[v].slave, vecs[v].hold,
               vecs[v].exp_lat, vecs[v].exp_gap, vecs[v].exp_rx, vecs[v].exp_mosi,
               $sformatf("vec%0d", v));
      if (vecs[v].hold) begin
        @(negedge clk);
        check($sformatf("vec%0d_restart_csn", v), 32'(csn[vecs[v].idx]), 32'd0);
        check($sformatf("vec%0d_restart_busy", v), 32'(busy[vecs[v].idx]), 32'd1);
        start = 1'b0;
      end
    end

    // Two bytes under CSHOLD on the CLKDIV=1 instance, MISO held low.
    apply_reset();
    txdata = 8'h9F; start = 1'b1; cshold = 1'b1;
    n_done = 0; csn_hi = 0; lead_seen = 0; dk0 = -1; dk1 = -1;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (start) start = 1'b0;
      if (k >= 2 && st[1] == ST_LEAD) lead_seen++;
      if (k <= 38 && csn[1]) csn_hi++;
      if (done[1]) begin
        if (n_done == 0) dk0 = k;
        else dk1 = k;
        n_done++;
        if (n_done == 1) begin
          check("hold_wait_busy", 32'(busy[1]), 32'd0);
          txdata = 8'h00;
          start = 1'b1;
        end
      end
      if (k == 19) check("hold_no_lead_state", 32'(st[1]), 32'(ST_XFER));
      if (k == 36) check("hold_cswait", 32'(st[1]), 32'(ST_CSWAIT));
      if (k == 37) cshold = 1'b0;
      if (k == 38) check("hold_trail", 32'(st[1]), 32'(ST_TRAIL));
      if (k == 39) check("hold_csn_rise", 32'(csn[1]), 32'd1);
    end
    check("hold_done1", 32'(dk0), 32'd18);
    check("hold_done2", 32'(dk1), 32'd35);
    check("hold_done_cnt", 32'(n_done), 32'd2);
    check("hold_csn_low", 32'(csn_hi), 32'd0);
    check("hold_lead_cnt", 32'(lead_seen), 32'd0);

    // ENABLE dropped at cycle 10 of a transfer on the CLKDIV=2 instance.
    apply_reset();
    run_byte(0, 2, 8'hA5, 8'h3C, 1'b0, 35, 2, 8'h3C, 8'hA5, "pre_abort");
    @(negedge clk);
    txdata = 8'h11; start = 1'b1;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort_busy_before", 32'(busy[0]), 32'd1);
    enable = 1'b0;
    #1;
    check("abort_oe", 32'({sclk_oe[0], mosi_oe[0], csn_oe[0]}), 32'h7);
    @(negedge clk);
    check("abort_state", 32'(st[0]), 32'(ST_IDLE));
    check("abort_csn", 32'(csn[0]), 32'd1);
    check("abort_sclk", 32'(sclk[0]), 32'd0);
    check("abort_rxdata", 32'(rxdata[0]), 32'h3C);
    n_done = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done[0]) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_rx_hold", 32'(rxdata[0]), 32'h3C);
    enable = 1'b1;

    // Asynchronous reset in the middle of XFER, then a clean transfer.
    apply_reset();
    txdata = 8'h77; start = 1'b1;
    for (k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_state_xfer", 32'(st[0]), 32'(ST_XFER));
    #2;
    rstn = 1'b0;
    #1;
    reset_checks("mid");
    n_done = 0;
    for (cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (done[0]) n_done++;
    end
    check("mid_no_done", 32'(n_done), 32'd0);
    rstn = 1'b1;
    run_byte(0, 2, 8'h96, 8'h69, 1'b0, 35, 2, 8'h69, 8'h96, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pfr_spi_master.md
PFR_SPI_MASTER -- requirements
Module: pfr_spi_master

Interface
REQ-001 SHALL have parameter CLKDIV, default 2, meaning SCLK half-period in CLK cycles; legal range 1..255.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ENABLE  input  1  1 = drive PFR SPI pins; 0 = release pins and abort.
REQ-005 SHALL have port START  input  1  request one byte transfer; sampled when BUSY=0 or in CS-hold.
REQ-006 SHALL have port CSHOLD  input  1  keep CSN low after the byte for a following byte.
REQ-007 SHALL have port TXDATA  input  8  byte to send, MSB first, captured on accepted START.
REQ-008 SHALL have port RXDATA  output  8  byte received; updated only with DONE.
REQ-009 SHALL have port BUSY  output  1  1 in every state except IDLE and CS-hold.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse at end of each byte.
REQ-011 SHALL have ports PFRMCLKO, PFRMOSIO, PFRCSNO  output  1 each  SCLK, MOSI and chip-select pin data.
REQ-012 SHALL have ports PFRMCLKOE, PFRMOSIOE, PFRCSNOE  output  1 each  tristate control; 1 = tristate, 0 = drive.
REQ-013 SHALL have ports PFRMISOO, PFRMISOOE  output  1 each  constant 0 and 1 (MISO is input-only).
REQ-014 SHALL have port PFRMISOI  input  1  MISO pin data.

Function
REQ-015 SHALL implement SPI mode 0: SCLK idles 0, MISO sampled on SCLK rising edge, MOSI changes on SCLK falling edge, MSB first.
REQ-016 SHALL drive PFRMCLKOE = PFRMOSIOE = PFRCSNOE = ~ENABLE combinationally.
REQ-017 SHALL use states IDLE, LEAD, XFER, TRAIL, CSWAIT.
REQ-018 SHALL generate a half-period tick every CLKDIV cycles; the counter clears on every state entry.
REQ-019 IDLE: CSN=1, SCLK=0; START=1 with ENABLE=1 loads TXDATA into the shift register, drives MOSI=TXDATA[7] and enters LEAD.
REQ-020 LEAD: CSN=0, SCLK=0 for one half-period; on the tick, enters XFER.
REQ-021 XFER: 16 ticks; odd ticks raise SCLK and shift PFRMISOI into the RX register; even ticks lower SCLK and present the next TX bit.
REQ-022 After the 16th tick, SHALL pulse DONE one cycle with RXDATA valid that cycle, SCLK=0, then enter CSWAIT if CSHOLD=1, else TRAIL.
REQ-023 For DIV=CLKDIV, DONE SHALL assert exactly 1+17*DIV cycles after the cycle START was accepted in IDLE.
REQ-024 TRAIL: CSN=0 for one half-period, then IDLE with CSN=1.
REQ-025 CSWAIT: CSN=0, SCLK=0; START=1 loads TXDATA and enters XFER directly (no LEAD); CSHOLD=0 with START=0 enters TRAIL; START wins if both apply.
REQ-026 SHALL ignore START while BUSY=1; TXDATA changes during a transfer SHALL NOT affect it.
REQ-027 ENABLE=0 in any state SHALL force IDLE on the next edge with CSN=1, SCLK=0, no DONE, and RXDATA unchanged.

Reset
REQ-028 RSTN=0 SHALL asynchronously force IDLE, PFRMCLKO=0, PFRMOSIO=0, PFRCSNO=1, RXDATA=0, BUSY=0, DONE=0, and clear the tick counter.
REQ-029 SHALL release reset synchronously to CLK (first transition on the first edge after RSTN=1); reset mid-transfer SHALL NOT produce DONE.

Structure
REQ-030 SHALL place the state enum and the divider counter width constant (8) in shared package pfr_spi_pkg.
REQ-031 SHALL implement the half-period tick generator as sub-module pfr_spi_clkdiv (CLK, RSTN, clear, tick).
REQ-032 SHALL keep all pin outputs registered, except the OE outputs and constant outputs.

Verification
REQ-033 CLKDIV=2, TXDATA=0xA5, slave model returns 0x3C -> MOSI bit sequence 1,0,1,0,0,1,0,1 observed at rising edges; RXDATA=0x3C; DONE at cycle 35; CSN high 2 cycles after DONE.
REQ-034 CLKDIV=1, CSHOLD=1, bytes 0x9F then 0x00 -> CSN stays low across both bytes, no LEAD before byte 2, two DONE pulses; CSN rises after CSHOLD drops.
REQ-035 ENABLE=0 at cycle 10 of a transfer -> all OE=1 the same cycle, state IDLE next edge, no DONE, RXDATA keeps its prior value.
REQ-036 RSTN pulsed low mid-XFER -> outputs reach reset values without a CLK edge; a new START after release completes normally.
REQ-037 START held high throughout and TXDATA toggled every cycle -> only the byte captured at acceptance is sent; the next byte starts only after TRAIL/IDLE.
REQ-038 CLKDIV=255, TXDATA=0xFF, MISO tied 0 -> SCLK high and low phases are each 255 cycles; RXDATA=0x00.
